// File: rtl/snes_pkg.sv
// Shared SNES pad-link definitions used by the pad emulator and the bus snooper.
// Word width, button bit positions on the wire, and the emulator state type.
package snes_pkg;

  localparam int SNES_BITS = 16;

  typedef logic [SNES_BITS-1:0] snes_word_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;
  // Bits 12..15 carry the controller ID.
  localparam int ID_LSB     = 12;

  typedef enum logic {
    ST_LOAD,
    ST_SHIFT
  } snes_state_e;

endpackage

// File: rtl/snes_sync_edge.sv
// Synchronizer plus rising-edge detect for one console pin.
// SNES_PAD_GLITCH_FILTER_EN adds a stability filter after the synchronizer.
module snes_sync_edge
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   synced;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

  assign synced = sync[SYNC_STAGES-1];

`ifdef SNES_PAD_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // Level only follows once the new value held for FILTER_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (synced == filt) begin
      cnt  <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      cnt  <= '0;
      filt <= synced;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

  assign level = filt;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/snes_pad_emulator.sv
// SNES controller-side emulator: shifts a 16-bit pad word out to the console.
// Define SNES_PAD_GLITCH_FILTER_EN to filter the latch/clk inputs.
module snes_pad_emulator
  import snes_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter logic FILL_BIT      = 1'b0,
  parameter int   FILTER_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       snes_latch,
  input  logic       snes_clk,
  input  snes_word_t pad_state,
  input  logic       pad_load,
  output logic       snes_data,
  output logic       busy,
  output logic       frame_done
);

  logic        latch_level;
  logic        latch_rise;
  logic        clk_level;
  logic        clk_rise;
  snes_state_e state;
  snes_word_t  shadow;
  snes_word_t  shift;
  logic [4:0]  count;
  logic        done_pend;

  snes_sync_edge #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch (
    .clk  (clk),
    .reset(reset),
    .din  (snes_latch),
    .level(latch_level),
    .rise (latch_rise)
  );

  snes_sync_edge #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk (
    .clk  (clk),
    .reset(reset),
    .din  (snes_clk),
    .level(clk_level),
    .rise (clk_rise)
  );

  assign state = latch_level ? ST_LOAD : ST_SHIFT;

  // done_pend delays the pulse so it lines up with FILL_BIT on snes_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow     <= 16'hFFFF;
      shift      <= 16'hFFFF;
      count      <= 5'd16;
      snes_data  <= 1'b1;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (pad_load) begin
        shadow <= pad_state;
      end
      done_pend  <= 1'b0;
      frame_done <= done_pend;
      snes_data  <= shift[0];
      unique case (state)
        ST_LOAD: begin
          shift <= pad_load ? pad_state : shadow;
          count <= 5'd0;
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            shift <= {FILL_BIT, shift[SNES_BITS-1:1]};
            if (count != 5'd16) begin
              count <= count + 5'd1;
            end
            if (count == 5'd15) begin
              done_pend <= 1'b1;
            end
          end
        end
        default: begin
          count <= 5'd16;
        end
      endcase
    end
  end

  assign busy = (count >= 5'd1) && (count <= 5'd15) && !latch_level;

  logic unused;
  assign unused = latch_rise ^ clk_level;

endmodule

// File: tb/tb_snes_pad_emulator.sv
// Self-checking bench for snes_pad_emulator: console-side protocol driver
// compared against a bit-stream model of the pad word.
module tb_snes_pad_emulator;

  localparam logic FILL = 1'b0;
  localparam int   H    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        snes_latch;
  logic        snes_clk;
  logic [15:0] pad_state;
  logic        pad_load;
  logic        snes_data;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int dones  = 0;
  logic fd_data = 1'b1;

  snes_pad_emulator #(
    .SYNC_STAGES  (2),
    .FILL_BIT     (FILL),
    .FILTER_CYCLES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .snes_latch(snes_latch),
    .snes_clk  (snes_clk),
    .pad_state (pad_state),
    .pad_load  (pad_load),
    .snes_data (snes_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) begin
      dones   <= dones + 1;
      fd_data <= snes_data;
    end
  end

  initial begin
    #3ms;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [15:0] w);
    @(negedge clk);
    pad_state = w;
    pad_load  = 1'b1;
    @(negedge clk);
    pad_load  = 1'b0;
  endtask

  // Console side: latch pulse, then n clk pulses; bit i sampled before rise i.
  task automatic run_frame(input int n, input bit late_load,
                           input logic [15:0] lw, input int glitch_at,
                           output logic [31:0] bits, output logic busy_mid);
    bits     = '0;
    busy_mid = 1'bx;
    snes_latch = 1'b1;
    repeat (H - 1) @(negedge clk);
    if (late_load) begin
      pad_state = lw;
      pad_load  = 1'b1;
    end
    @(negedge clk);
    pad_load   = 1'b0;
    snes_latch = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i == glitch_at) begin
        snes_clk = 1'b1;
        @(negedge clk);
        snes_clk = 1'b0;
        repeat (H) @(negedge clk);
      end
      bits[i] = snes_data;
      if (i == 5) busy_mid = busy;
      snes_clk = 1'b1;
      repeat (H) @(negedge clk);
      snes_clk = 1'b0;
      repeat (H) @(negedge clk);
    end
    bits[n] = snes_data;
  endtask

  // Model: the wire carries word bits 0..15 then FILL forever; each console
  // clk rise (real or glitch) consumes one position of that stream.
  function automatic logic [31:0] expect_bits(input logic [15:0] w,
                                              input int n, input int gl);
    logic [31:0] r;
    int pos;
    r = '0;
    for (int i = 0; i <= n; i++) begin
      pos = i;
      if (gl >= 0 && i >= gl) pos = i + 1;
      r[i] = (pos < 16) ? w[pos] : FILL;
    end
    return r;
  endfunction

  function automatic logic [31:0] mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i <= n; i++) m[i] = 1'b1;
    return m;
  endfunction

  initial begin
    logic [31:0] got;
    logic        bm;
    logic [15:0] w;
    int          d0;
    int          gl;

    reset      = 1'b1;
    snes_latch = 1'b0;
    snes_clk   = 1'b0;
    pad_state  = '0;
    pad_load   = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_data", 32'(snes_data), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_data", 32'(snes_data), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_dones", 32'(dones), 32'd0);

    // Normal frame with the documented pattern
    load(16'hFEFE);
    d0 = dones;
    run_frame(16, 1'b0, '0, -1, got, bm);
    chk("normal_bits", got & mask(16), expect_bits(16'hFEFE, 16, -1));
    chk("normal_busy_mid", 32'(bm), 32'd1);
    chk("normal_done", 32'(dones - d0), 32'd1);
    chk("normal_fd_fill", 32'(fd_data), 32'(FILL));
    chk("normal_after", 32'(snes_data), 32'(FILL));
    chk("normal_busy_end", 32'(busy), 32'd0);

    // Overclocking: extra pulses read FILL, still one pulse
    w = 16'(($urandom));
    load(w);
    d0 = dones;
    run_frame(20, 1'b0, '0, -1, got, bm);
    chk("over_bits", got & mask(20), expect_bits(w, 20, -1));
    chk("over_done", 32'(dones - d0), 32'd1);

    // Random words
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      load(w);
      d0 = dones;
      run_frame(16, 1'b0, '0, -1, got, bm);
      chk("rand_bits", got & mask(16), expect_bits(w, 16, -1));
      chk("rand_done", 32'(dones - d0), 32'd1);
    end

    // Load while latch is high, one cycle before it falls
    d0 = dones;
    run_frame(16, 1'b1, 16'h0001, -1, got, bm);
    chk("late_load_bits", got & mask(16), expect_bits(16'h0001, 16, -1));
    chk("late_load_done", 32'(dones - d0), 32'd1);

    // Abort after 5 bits, then a fresh frame from shadow[0]
    w = 16'($urandom) ^ 16'h5A3C;
    load(w);
    d0 = dones;
    run_frame(5, 1'b0, '0, -1, got, bm);
    chk("abort_part", got & mask(5), expect_bits(w, 5, -1));
    chk("abort_busy", 32'(busy), 32'd1);
    run_frame(16, 1'b0, '0, -1, got, bm);
    chk("abort_restart", got & mask(16), expect_bits(w, 16, -1));
    chk("abort_done", 32'(dones - d0), 32'd1);

    // Single-cycle clk glitch before bit 6
`ifdef SNES_PAD_GLITCH_FILTER_EN
    gl = -1;
`else
    gl = 6;
`endif
    w = 16'($urandom) | 16'h0100;
    w[7] = ~w[6];
    load(w);
    d0 = dones;
    run_frame(16, 1'b0, '0, 6, got, bm);
    chk("glitch_bits", got & mask(16), expect_bits(w, 16, gl));
    chk("glitch_done", 32'(dones - d0), 32'd1);

    // Reset mid-frame returns to reset state and shadow
    load(16'h1234);
    run_frame(3, 1'b0, '0, -1, got, bm);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_data", 32'(snes_data), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    d0 = dones;
    run_frame(16, 1'b0, '0, -1, got, bm);
    chk("midreset_frame", got & mask(16), expect_bits(16'hFFFF, 16, -1));
    chk("midreset_done", 32'(dones - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
